// File: rtl/serial_twos_comp_mc.sv
// Multi-channel word-framed serial two's complementer, LSB first.
// Mealy serial output per channel, plus registered result word and overflow.
//
// Ports:
//   clk, rst     rising-edge clock, async active-high reset
//   in_valid     per channel: bit on x_in accepted this cycle
//   x_in         per channel: serial data bit, LSB first
//   frame_start  per channel: accepted bit is bit 0 of a new word
//   neg_en       per channel: sampled on bit 0, 1 = negate the word
//   y_out        per channel: combinational result bit
//   y_valid      per channel: mirrors in_valid
//   word_done    per channel: one-cycle pulse after the MSB is accepted
//   word_out     channel c at [c*WIDTH +: WIDTH], registered result word
//   ovf          per channel: most-negative value was negated
module serial_twos_comp_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       x_in,
  input  logic [CHANNELS-1:0]       frame_start,
  input  logic [CHANNELS-1:0]       neg_en,
  output logic [CHANNELS-1:0]       y_out,
  output logic [CHANNELS-1:0]       y_valid,
  output logic [CHANNELS-1:0]       word_done,
  output logic [CHANNELS*WIDTH-1:0] word_out,
  output logic [CHANNELS-1:0]       ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign y_valid = in_valid;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CW-1:0]    cnt_q;
    logic             seen_q;
    logic             neg_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] wo_q;
    logic             done_q;
    logic             ovf_q;
    logic             first;
    logic             seen_e;
    logic             neg_e;
    logic             last;
    logic             y;
    logic [WIDTH-1:0] nxt;

    always_comb begin
      first  = frame_start[c] | (cnt_q == '0);
      seen_e = first ? 1'b0 : seen_q;
      neg_e  = first ? neg_en[c] : neg_q;
      // bits after the first 1 are inverted when negating
      y      = in_valid[c] & (x_in[c] ^ (neg_e & seen_e));
      // a frame_start forces index 0, which is never the MSB
      last   = ~frame_start[c] & (cnt_q == LAST);
    end

    assign nxt = {y, sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        seen_q <= 1'b0;
        neg_q  <= 1'b0;
        sh_q   <= '0;
        wo_q   <= '0;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (in_valid[c]) begin
          neg_q <= neg_e;
          sh_q  <= nxt;
          if (last) begin
            cnt_q  <= '0;
            seen_q <= 1'b0;
            wo_q   <= nxt;
            done_q <= 1'b1;
            // only 100..0 has no 1 below the MSB
            ovf_q  <= neg_e & ~seen_e & x_in[c];
          end else begin
            cnt_q  <= frame_start[c] ? CW'(1) : cnt_q + CW'(1);
            seen_q <= seen_e | x_in[c];
          end
        end
      end
    end

    assign y_out[c]                 = y;
    assign word_done[c]             = done_q;
    assign ovf[c]                   = ovf_q;
    assign word_out[c*WIDTH+:WIDTH] = wo_q;
  end

endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// Self-checking bench for serial_twos_comp_mc.
// Word-level arithmetic model plus directed literal checks.
module tb_serial_twos_comp_mc;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   x_in = '0;
  logic [N-1:0]   frame_start = '0;
  logic [N-1:0]   neg_en = '0;
  logic [N-1:0]   y_out;
  logic [N-1:0]   y_valid;
  logic [N-1:0]   word_done;
  logic [N*W-1:0] word_out;
  logic [N-1:0]   ovf;

  int errors = 0;
  int checks = 0;

  serial_twos_comp_mc #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .x_in(x_in),
    .frame_start(frame_start),
    .neg_en(neg_en),
    .y_out(y_out),
    .y_valid(y_valid),
    .word_done(word_done),
    .word_out(word_out),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: bits accepted so far form a partial value a; the result
  // is -a (mod 2^W) or a, and its bit i is the serial output
  int         m_idx [N];
  int         m_acc [N];
  bit         m_neg [N];
  logic [7:0] m_wo  [N];
  bit         m_done[N];
  bit         m_ovf [N];

  function automatic void eval(input int c, output int i, output int a,
                               output bit n, output logic [7:0] r);
    i = frame_start[c] ? 0 : m_idx[c];
    a = ((i == 0) ? 0 : m_acc[c]) + (int'(x_in[c]) << i);
    n = (i == 0) ? neg_en[c] : m_neg[c];
    r = n ? 8'(-a) : 8'(a);
  endfunction

  always @(posedge clk or posedge rst) begin
    int i, a;
    bit n;
    logic [7:0] r;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_idx[c] = 0; m_acc[c] = 0; m_neg[c] = 0;
        m_wo[c] = 0; m_done[c] = 0; m_ovf[c] = 0;
      end else begin
        m_done[c] = 0;
        if (in_valid[c]) begin
          eval(c, i, a, n, r);
          m_neg[c] = n;
          if (i == W - 1) begin
            m_idx[c] = 0; m_acc[c] = 0;
            m_wo[c] = r; m_done[c] = 1;
            m_ovf[c] = n && (a == (1 << (W - 1)));
          end else begin
            m_idx[c] = i + 1; m_acc[c] = a;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    int i, a;
    bit n;
    logic [7:0] r;
    bit ey;
    for (int c = 0; c < N; c++) begin
      eval(c, i, a, n, r);
      ey = in_valid[c] & r[i];
      chk($sformatf("y_out[%0d]", c), 32'(y_out[c]), 32'(ey));
      chk($sformatf("y_valid[%0d]", c), 32'(y_valid[c]),
          32'(in_valid[c]));
      chk($sformatf("word_done[%0d]", c), 32'(word_done[c]),
          32'(m_done[c]));
      chk($sformatf("ovf[%0d]", c), 32'(ovf[c]), 32'(m_ovf[c]));
      chk($sformatf("word_out[%0d]", c), 32'(word_out[c*W+:W]),
          32'(m_wo[c]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0; x_in = '0; frame_start = '0; neg_en = '0;
  endtask

  logic ylog [W];

  // one word on channel c; neg_en is flipped after bit 0 to show latching
  task automatic send(int c, logic [7:0] v, bit ne, bit fs0,
                      int gap_at, int gap_len);
    for (int i = 0; i < W; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid[c] = 1'b0; x_in[c] = 1'b1; neg_en[c] = 1'b1;
          #1;
          chk("gap_y", 32'(y_out[c]), 32'd0);
          tick();
        end
      end
      in_valid[c] = 1'b1;
      x_in[c] = v[i];
      frame_start[c] = fs0 && (i == 0);
      neg_en[c] = (i == 0) ? ne : ~ne;
      #1;
      ylog[i] = y_out[c];
      tick();
    end
  endtask

  logic [7:0] wv [N];
  bit         wn [N];

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk("reset_word_out", word_out, 32'd0);
    chk("reset_done", 32'(word_done), 32'd0);
    rst = 1'b0;
    tick();

    // 1: 0x05 negated on channel 0
    send(0, 8'h05, 1, 0, -1, 0);
    idle();
    chk("t1_y", {24'd0, ylog[7], ylog[6], ylog[5], ylog[4],
                 ylog[3], ylog[2], ylog[1], ylog[0]}, 32'hFB);
    chk("t1_word", 32'(word_out[7:0]), 32'hFB);
    chk("t1_done", 32'(word_done[0]), 32'd1);
    chk("t1_ovf", 32'(ovf[0]), 32'd0);
    tick();
    chk("t1_done_off", 32'(word_done[0]), 32'd0);

    // 2: pass-through then back-to-back negated zero
    send(1, 8'h05, 0, 0, -1, 0);
    chk("t2_y", {24'd0, ylog[7], ylog[6], ylog[5], ylog[4],
                 ylog[3], ylog[2], ylog[1], ylog[0]}, 32'h05);
    chk("t2_word", 32'(word_out[15:8]), 32'h05);
    chk("t2_done", 32'(word_done[1]), 32'd1);
    send(1, 8'h00, 1, 0, -1, 0);
    idle();
    chk("t2_word0", 32'(word_out[15:8]), 32'h00);
    chk("t2_ovf", 32'(ovf[1]), 32'd0);
    tick();

    // 3: most-negative value, then 0x7F
    send(2, 8'h80, 1, 0, -1, 0);
    idle();
    chk("t3_word", 32'(word_out[23:16]), 32'h80);
    chk("t3_ovf", 32'(ovf[2]), 32'd1);
    tick();
    chk("t3_ovf_hold", 32'(ovf[2]), 32'd1);
    send(2, 8'h7F, 1, 0, -1, 0);
    idle();
    chk("t3_word2", 32'(word_out[23:16]), 32'h81);
    chk("t3_ovf2", 32'(ovf[2]), 32'd0);
    tick();

    // 4: gap of 3 invalid cycles after bit 2
    send(3, 8'h06, 1, 0, 3, 3);
    idle();
    chk("t4_word", 32'(word_out[31:24]), 32'hFA);
    chk("t4_done", 32'(word_done[3]), 32'd1);
    tick();

    // 5: abort after 4 bits, restart with 0x03 negated
    send(0, 8'h00, 1, 0, -1, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1; x_in[0] = 1'b1; neg_en[0] = 1'b1;
      tick();
    end
    for (int i = 0; i < W; i++) begin
      in_valid[0] = 1'b1;
      x_in[0] = (i < 2);
      frame_start[0] = (i == 0);
      neg_en[0] = (i == 0);
      tick();
      if (i == 3) chk("t5_no_done", 32'(word_done[0]), 32'd0);
      if (i < W - 1) chk("t5_word_hold", 32'(word_out[7:0]), 32'h00);
    end
    idle();
    chk("t5_word", 32'(word_out[7:0]), 32'hFD);
    chk("t5_done", 32'(word_done[0]), 32'd1);
    tick();

    // 6: reset mid-word on all channels, then concurrent words
    for (int i = 0; i < 4; i++) begin
      in_valid = '1; x_in = 4'b0110; neg_en = 4'b1010;
      tick();
    end
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_word", word_out, 32'd0);
    chk("t6_rst_done", 32'(word_done), 32'd0);
    chk("t6_rst_ovf", 32'(ovf), 32'd0);
    chk("t6_rst_y", 32'(y_out), 32'd0);
    in_valid = '1; x_in = 4'b1010; neg_en = '1;
    #1;
    chk("t6_rst_y2", 32'(y_out), 32'hA);
    idle();
    tick();
    rst = 1'b0;
    tick();
    wv[0] = 8'h01; wn[0] = 1;
    wv[1] = 8'h80; wn[1] = 1;
    wv[2] = 8'h3C; wn[2] = 0;
    wv[3] = 8'h7F; wn[3] = 1;
    for (int i = 0; i < W; i++) begin
      for (int c = 0; c < N; c++) begin
        in_valid[c] = 1'b1;
        x_in[c] = wv[c][i];
        neg_en[c] = (i == 0) ? wn[c] : ~wn[c];
      end
      tick();
    end
    idle();
    chk("t6_w0", 32'(word_out[7:0]), 32'hFF);
    chk("t6_w1", 32'(word_out[15:8]), 32'h80);
    chk("t6_w2", 32'(word_out[23:16]), 32'h3C);
    chk("t6_w3", 32'(word_out[31:24]), 32'h81);
    chk("t6_ovf", 32'(ovf), 32'h2);
    chk("t6_done", 32'(word_done), 32'hF);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
